// File: rtl/drive_ctrl_fsm.sv
// Manual-drive controller: synchronised/debounced driver inputs, power and drive FSMs, blinking turn lights.
// Raw input reaches the debounced level after 2+DEBOUNCE_CYCLES cycles and outputs one cycle later; inputs are free-running levels with no backpressure.
module drive_ctrl_fsm #(
  parameter int DEBOUNCE_CYCLES   = 1_000_000,
  parameter int POWER_HOLD_CYCLES = 100_000_000,
  parameter int BLINK_HALF_CYCLES = 50_000_000,
  parameter int CNT_W             = 32
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       power_on,
  input  logic       power_off,
  input  logic       clutch,
  input  logic       throttle,
  input  logic       brake,
  input  logic       rgs,
  input  logic       left,
  input  logic       right,
  output logic       power,
  output logic [1:0] state,
  output logic [3:0] moving_state,
  output logic       turn_left_light,
  output logic       turn_right_light,
  output logic       fault
);

  localparam int NIN = 8;
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(POWER_HOLD_CYCLES);
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_HALF_CYCLES - 1);

  typedef enum logic {PWR_OFF = 1'b0, PWR_ON = 1'b1} pwr_t;
  typedef enum logic [1:0] {NOT_STARTING = 2'b00, STARTING = 2'b01, MOVING = 2'b10} drv_t;

  logic [NIN-1:0] raw, sync1, sync2, db;
  assign raw = {right, left, rgs, brake, throttle, clutch, power_off, power_on};

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Any cycle where the synchronised value matches db restarts the stability count.
  for (genvar i = 0; i < NIN; i++) begin : g_db
    logic [CNT_W-1:0] cnt;
    logic             val;
    always_ff @(posedge sys_clk) begin
      if (rst) begin
        cnt <= '0;
        val <= 1'b0;
      end else if (sync2[i] != val) begin
        if (cnt == DB_LAST) begin
          cnt <= '0;
          val <= sync2[i];
        end else begin
          cnt <= cnt + ONE;
        end
      end else begin
        cnt <= '0;
      end
    end
    assign db[i] = val;
  end

  logic db_power_on, db_power_off, db_clutch, db_throttle, db_brake, db_rgs, db_left, db_right;
  assign {db_right, db_left, db_rgs, db_brake, db_throttle, db_clutch, db_power_off, db_power_on} = db;

  pwr_t             pwr_q, pwr_nxt;
  drv_t             drv_q, drv_nxt;
  logic [CNT_W-1:0] hold_q, hold_nxt, blink_q, blink_nxt;
  logic             phase_q, phase_nxt, rgs_ref_q, rgs_ref_nxt, pwr_off_q;
  logic [3:0]       ms_q, ms_nxt;
  logic             tl_q, tl_nxt, tr_q, tr_nxt, fault_q, fault_nxt, on_nxt;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      pwr_q     <= PWR_OFF;
      drv_q     <= NOT_STARTING;
      hold_q    <= '0;
      blink_q   <= '0;
      phase_q   <= 1'b1;
      rgs_ref_q <= 1'b0;
      pwr_off_q <= 1'b0;
      ms_q      <= '0;
      tl_q      <= 1'b0;
      tr_q      <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      pwr_q     <= pwr_nxt;
      drv_q     <= drv_nxt;
      hold_q    <= hold_nxt;
      blink_q   <= blink_nxt;
      phase_q   <= phase_nxt;
      rgs_ref_q <= rgs_ref_nxt;
      pwr_off_q <= db_power_off;
      ms_q      <= ms_nxt;
      tl_q      <= tl_nxt;
      tr_q      <= tr_nxt;
      fault_q   <= fault_nxt;
    end
  end

  always_comb begin
    pwr_nxt     = pwr_q;
    drv_nxt     = drv_q;
    hold_nxt    = '0;
    blink_nxt   = '0;
    phase_nxt   = 1'b1;
    rgs_ref_nxt = rgs_ref_q;
    fault_nxt   = 1'b0;
    case (pwr_q)
      PWR_OFF: begin
        if (hold_q == HOLD_LAST) begin
          pwr_nxt = PWR_ON;
        end else if (db_power_on) begin
          hold_nxt = hold_q + ONE;
        end
      end
      PWR_ON: begin
        if (db_power_off && !pwr_off_q) begin
          pwr_nxt = PWR_OFF;
        end else if (db_brake) begin
          drv_nxt = NOT_STARTING;
        end else begin
          case (drv_q)
            NOT_STARTING: begin
              if (db_throttle && db_clutch) drv_nxt = STARTING;
              else if (db_throttle)         fault_nxt = 1'b1;
            end
            STARTING: begin
              if (db_throttle && !db_clutch) begin
                drv_nxt     = MOVING;
                rgs_ref_nxt = db_rgs;
              end
            end
            MOVING: begin
              if (db_rgs != rgs_ref_q)           fault_nxt = 1'b1;
              else if (db_clutch || !db_throttle) drv_nxt = STARTING;
            end
            default: drv_nxt = NOT_STARTING;
          endcase
        end
        if (fault_nxt) pwr_nxt = PWR_OFF;
        // Blink phase only advances while power stays on; any off period restarts it high.
        if (pwr_nxt == PWR_ON) begin
          if (blink_q == BLINK_LAST) begin
            phase_nxt = ~phase_q;
          end else begin
            blink_nxt = blink_q + ONE;
            phase_nxt = phase_q;
          end
        end
      end
      default: pwr_nxt = PWR_OFF;
    endcase
    if (pwr_nxt == PWR_OFF) drv_nxt = NOT_STARTING;

    on_nxt    = (pwr_nxt == PWR_ON);
    ms_nxt[0] = (drv_nxt == MOVING) && !db_rgs;
    ms_nxt[1] = (drv_nxt == MOVING) && db_rgs;
    ms_nxt[2] = on_nxt && (drv_nxt != NOT_STARTING) && db_left && !db_right;
    ms_nxt[3] = on_nxt && (drv_nxt != NOT_STARTING) && db_right && !db_left;
    tl_nxt    = on_nxt && db_left && !db_right && phase_nxt;
    tr_nxt    = on_nxt && db_right && !db_left && phase_nxt;
  end

  assign power            = (pwr_q == PWR_ON);
  assign state            = drv_q;
  assign moving_state     = ms_q;
  assign turn_left_light  = tl_q;
  assign turn_right_light = tr_q;
  assign fault            = fault_q;

endmodule

// File: tb/tb_drive_ctrl_fsm.sv
// Directed bench for drive_ctrl_fsm with short timing constants (debounce 4, hold 10, blink half-period 5).
module tb_drive_ctrl_fsm;

  logic       sys_clk, rst;
  logic       power_on, power_off, clutch, throttle, brake, rgs, left, right;
  logic       power, turn_left_light, turn_right_light, fault;
  logic [1:0] state;
  logic [3:0] moving_state;

  int n_chk  = 0;
  int n_fail = 0;

  drive_ctrl_fsm #(
    .DEBOUNCE_CYCLES  (4),
    .POWER_HOLD_CYCLES(10),
    .BLINK_HALF_CYCLES(5),
    .CNT_W            (32)
  ) dut (
    .sys_clk         (sys_clk),
    .rst             (rst),
    .power_on        (power_on),
    .power_off       (power_off),
    .clutch          (clutch),
    .throttle        (throttle),
    .brake           (brake),
    .rgs             (rgs),
    .left            (left),
    .right           (right),
    .power           (power),
    .state           (state),
    .moving_state    (moving_state),
    .turn_left_light (turn_left_light),
    .turn_right_light(turn_right_light),
    .fault           (fault)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Inputs change and outputs are sampled 1 time unit after a rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  // Expected output vector: {power, state, moving_state, left light, right light, fault}.
  function automatic logic [9:0] mk(input logic p, input logic [1:0] st, input logic [3:0] ms,
                                    input logic tl, input logic tr, input logic f);
    return {p, st, ms, tl, tr, f};
  endfunction

  task automatic chk(input string tag, input logic [9:0] exp);
    logic [9:0] obs;
    obs = {power, state, moving_state, turn_left_light, turn_right_light, fault};
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed {pwr,st,ms,tl,tr,flt}=%b expected %b", tag, obs, exp);
    end
  endtask

  task automatic power_up(input string tag);
    power_on = 1'b1;
    tick(17);
    chk(tag, mk(1'b1, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0));
    power_on = 1'b0;
    tick(8);
  endtask

  task automatic power_down(input string tag);
    power_off = 1'b1;
    tick(7);
    chk(tag, mk(1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0));
    power_off = 1'b0;
    tick(8);
  endtask

  initial begin
    rst = 1'b1;
    {power_on, power_off, clutch, throttle, brake, rgs, left, right} = '0;
    tick(3);
    chk("reset", mk(1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0));
    rst = 1'b0;

    // Power-on latency: 2 sync + 4 debounce + 10 hold + 1 edges.
    power_on = 1'b1;
    tick(16);
    chk("pon_early", mk(1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0));
    tick(1);
    chk("pon_exact", mk(1'b1, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0));
    power_on = 1'b0;
    tick(8);
    chk("pon_stay", mk(1'b1, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0));
    power_off = 1'b1;
    tick(6);
    chk("poff_wait", mk(1'b1, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0));
    tick(1);
    chk("poff", mk(1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0));
    power_off = 1'b0;
    tick(8);

    power_on = 1'b1;
    tick(8);
    power_on = 1'b0;
    tick(20);
    chk("pon_short", mk(1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0));

    // power_off held together with power_on while off does not block power-up.
    power_on  = 1'b1;
    power_off = 1'b1;
    tick(17);
    chk("both_on", mk(1'b1, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0));
    power_on  = 1'b0;
    power_off = 1'b0;
    tick(8);
    chk("both_hold", mk(1'b1, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0));
    power_down("both_down");

    // Start, move, then reverse-gear toggle faults.
    power_up("pu_move");
    clutch   = 1'b1;
    throttle = 1'b1;
    tick(6);
    chk("start_wait", mk(1'b1, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0));
    tick(1);
    chk("starting", mk(1'b1, 2'b01, 4'b0000, 1'b0, 1'b0, 1'b0));
    clutch = 1'b0;
    tick(7);
    chk("moving", mk(1'b1, 2'b10, 4'b0001, 1'b0, 1'b0, 1'b0));
    rgs = 1'b1;
    tick(6);
    chk("rgs_wait", mk(1'b1, 2'b10, 4'b0001, 1'b0, 1'b0, 1'b0));
    tick(1);
    chk("rgs_fault", mk(1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b1));
    tick(1);
    chk("rgs_fault_end", mk(1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0));
    throttle = 1'b0;
    rgs      = 1'b0;
    tick(8);

    // Throttle without clutch from standstill.
    power_up("pu_err");
    throttle = 1'b1;
    tick(7);
    chk("err_fault", mk(1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b1));
    tick(1);
    chk("err_fault_end", mk(1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0));
    throttle = 1'b0;
    tick(8);

    // Brake outranks clutch in MOVING.
    power_up("pu_brake");
    clutch   = 1'b1;
    throttle = 1'b1;
    tick(7);
    chk("br_starting", mk(1'b1, 2'b01, 4'b0000, 1'b0, 1'b0, 1'b0));
    clutch = 1'b0;
    tick(7);
    chk("br_moving", mk(1'b1, 2'b10, 4'b0001, 1'b0, 1'b0, 1'b0));
    brake  = 1'b1;
    clutch = 1'b1;
    tick(7);
    chk("brake", mk(1'b1, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0));
    throttle = 1'b0;
    tick(8);
    brake  = 1'b0;
    clutch = 1'b0;
    tick(8);
    chk("brake_rel", mk(1'b1, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0));
    power_down("br_down");

    // Turn lights: phase high on power-on edge k, toggling every 5 edges.
    left = 1'b1;
    tick(8);
    power_on = 1'b1;
    tick(17);
    chk("lt_k0", mk(1'b1, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0));
    power_on = 1'b0;
    tick(4);
    chk("lt_k4", mk(1'b1, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0));
    tick(1);
    chk("lt_k5", mk(1'b1, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0));
    tick(4);
    chk("lt_k9", mk(1'b1, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0));
    tick(1);
    chk("lt_k10", mk(1'b1, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0));
    clutch   = 1'b1;
    throttle = 1'b1;
    tick(7);
    chk("lt_starting", mk(1'b1, 2'b01, 4'b0100, 1'b0, 1'b0, 1'b0));
    right = 1'b1;
    tick(7);
    chk("lt_cancel", mk(1'b1, 2'b01, 4'b0000, 1'b0, 1'b0, 1'b0));
    left  = 1'b0;
    right = 1'b0;
    tick(8);
    right = 1'b1;
    tick(7);
    chk("rt_k39", mk(1'b1, 2'b01, 4'b1000, 1'b0, 1'b0, 1'b0));
    tick(1);
    chk("rt_k40", mk(1'b1, 2'b01, 4'b1000, 1'b0, 1'b1, 1'b0));
    right = 1'b0;
    tick(8);
    chk("rt_off", mk(1'b1, 2'b01, 4'b0000, 1'b0, 1'b0, 1'b0));

    // Short power_off glitch is filtered.
    power_off = 1'b1;
    tick(3);
    power_off = 1'b0;
    tick(10);
    chk("glitch", mk(1'b1, 2'b01, 4'b0000, 1'b0, 1'b0, 1'b0));

    // Synchronous reset while moving.
    clutch = 1'b0;
    tick(7);
    chk("rst_moving", mk(1'b1, 2'b10, 4'b0001, 1'b0, 1'b0, 1'b0));
    rst = 1'b1;
    tick(1);
    chk("rst_hit", mk(1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0));
    rst = 1'b0;
    throttle = 1'b0;
    tick(3);
    chk("rst_after", mk(1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/drive_ctrl_fsm.md
Name: drive_ctrl_fsm

Overview:
- Parametrised successor of the manual-drive controller in the simulated-device top.
- Input conditioning: synchronises and debounces all driver controls.
- Core logic: power on/off state machine and drive-state machine (not-starting / starting / moving), all fully registered.
- Outputs: the 4-bit moving_state nibble consumed by the UART frame builder, plus turn lights that blink at a configurable rate.
- Timing constants are parameters so the same RTL runs on board (100 MHz) and in fast simulation.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles before a synchronised input is accepted (>=1).
- POWER_HOLD_CYCLES, 100_000_000, cycles power_on must be held (debounced) before power goes on (>=1).
- BLINK_HALF_CYCLES, 50_000_000, half-period of the turn-light blink (>=1).
- CNT_W, 32, width of all internal counters; must hold the largest parameter.

Ports:
- sys_clk  in  1  system clock (100 MHz on board).
- rst  in  1  reset, synchronous and active-high.
- power_on  in  1  power-on button (raw).
- power_off  in  1  power-off button (raw).
- clutch  in  1  clutch (raw level).
- throttle  in  1  throttle (raw level).
- brake  in  1  brake (raw level).
- rgs  in  1  reverse gear switch (raw level; 1 = reverse).
- left  in  1  turn-left control (raw level).
- right  in  1  turn-right control (raw level).
- power  out  1  1 = device powered.
- state  out  2  00 NOT_STARTING, 01 STARTING, 10 MOVING; 11 is never produced.
- moving_state  out  4  bit0 forward, bit1 backward, bit2 left, bit3 right.
- turn_left_light  out  1  blinking left indicator.
- turn_right_light  out  1  blinking right indicator.
- fault  out  1  one-cycle pulse when a driving error forces power off.

Behaviour:
- Reset (rst=1 at a sys_clk edge):
  - All outputs 0, state=00.
  - Sync/debounce registers, debounced values and all counters cleared.
  - Reset mid-operation (any state, any count) takes effect on that same edge.
- Input conditioning, per input:
  - 2-FF synchroniser feeds a debouncer.
  - The debounced value db takes the synchronised value once that value has differed from db for DEBOUNCE_CYCLES consecutive cycles.
  - Any mismatch gap restarts the count.
  - Raw change to db change = 2 + DEBOUNCE_CYCLES cycles; FSM outputs change one cycle later.
- Power FSM:
  - OFF: hold counter increments each cycle db_power_on=1 and clears when db_power_on=0.
  - When the counter reaches POWER_HOLD_CYCLES, power goes 1 on the next edge, with state=NOT_STARTING.
  - ON -> OFF on a rising edge of db_power_off, or on a fault.
  - Going OFF forces state=00, moving_state=0, lights=0 and clears the blink counter.
  - While OFF, all drive inputs are ignored.
  - power_on and power_off both asserted while OFF: power_off has no effect; the hold counter still runs.
- Drive FSM (only while power=1). Evaluated each cycle on debounced levels; priority in listed order:
  - brake=1: any state -> NOT_STARTING.
  - NOT_STARTING:
    - throttle & clutch -> STARTING.
    - throttle & !clutch -> fault (power off, fault pulse).
  - STARTING: throttle & !clutch -> MOVING.
  - MOVING:
    - rgs toggled since entering MOVING -> fault.
    - clutch=1 or throttle=0 -> STARTING.
  - Otherwise hold.
- moving_state (registered, same edge as state):
  - bit0 = (state==MOVING) & !rgs.
  - bit1 = (state==MOVING) & rgs.
  - bit2 = power & (state!=NOT_STARTING) & left & !right.
  - bit3 = power & (state!=NOT_STARTING) & right & !left.
  - left & right together: both bits 0 (cancel).
- Turn lights:
  - Blink counter runs while power=1.
  - Every BLINK_HALF_CYCLES a phase flag toggles; phase starts at 1 after reset/power-on.
  - turn_left_light = power & db_left & !db_right & phase; right mirrored.
  - Lights are independent of drive state (the indicator works when stationary).
- fault:
  - High for exactly the one cycle in which power transitions 1 -> 0 due to an error.
  - Never asserted by power_off or reset.

Test Plan (DEBOUNCE_CYCLES=4, POWER_HOLD_CYCLES=10, BLINK_HALF_CYCLES=5):
- Power-on: hold power_on 20 cycles -> power=1 exactly 2+4+10+1 cycles after the raw rise, state=00. Release after 8 cycles -> power stays 0.
- Start and move: power on; clutch=1, throttle=1 -> state=01; then clutch=0 -> state=10, moving_state=0001. Set rgs=1 -> fault pulse 1 cycle, power=0, moving_state=0.
- Error start: power on, state=00, throttle=1 with clutch=0 -> fault=1 for 1 cycle, power=0, outputs all 0.
- Brake priority: in MOVING assert brake together with clutch -> state=00 (not 01), moving_state bits 0/1 clear.
- Lights: power on, left=1 -> turn_left_light toggles every 5 cycles, turn_right_light=0. In STARTING, moving_state=0100. left=right=1 -> both lights 0, bits 2/3 = 0.
- Glitch/reset: a 3-cycle power_off pulse is rejected (power stays 1). rst=1 while in MOVING -> next edge power=0, state=00, all outputs 0.
